// File: rtl/mul_pkg.sv
// Shared opcode encodings and stage payload widths for the RV32M multiply unit.
package mul_pkg;

   localparam logic [1:0] MUL_OP_MUL    = 2'b00;
   localparam logic [1:0] MUL_OP_MULH   = 2'b01;
   localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
   localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

   localparam int unsigned MUL_OP_W   = 2;
   localparam int unsigned MUL_OPND_W = 32;
   localparam int unsigned MUL_PROD_W = 64;
   localparam int unsigned MUL_RES_W  = 32;

endpackage

// File: rtl/mul_issue_unit_multiplier32.sv
// Multiplier32: combinational 32x32 unsigned multiplier, Wallace-style carry-save tree.
module Multiplier32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] product
);

   // Reduce 32 partial-product rows with 3:2 compressors (32->22->15->10->7->5->4->3->2), then one final add.
   always_comb begin
      logic [63:0] cur [32];
      logic [63:0] nxt [32];
      logic [63:0] r0, r1, r2;
      int unsigned n, m, base;

      for (int unsigned i = 0; i < 32; i++) begin
         cur[i] = b[i] ? ({32'b0, a} << i) : '0;
      end
      n = 32;

      for (int unsigned lvl = 0; lvl < 8; lvl++) begin
         for (int unsigned i = 0; i < 32; i++) begin
            nxt[i] = '0;
         end
         m = 0;
         for (int unsigned g = 0; g < 11; g++) begin
            base = 3 * g;
            if (base + 2 < n) begin
               r0 = cur[5'(base)];
               r1 = cur[5'(base + 1)];
               r2 = cur[5'(base + 2)];
               nxt[5'(m)]     = r0 ^ r1 ^ r2;
               nxt[5'(m + 1)] = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
               m = m + 2;
            end
         end
         // Rows left over after grouping by three pass straight through to the next level.
         for (int unsigned j = 0; j < 3; j++) begin
            base = 3 * (n / 3) + j;
            if (base < n) begin
               nxt[5'(m)] = cur[5'(base)];
               m = m + 1;
            end
         end
         cur = nxt;
         n   = m;
      end

      product = cur[0] + cur[1];
   end

endmodule

// File: rtl/mul_issue_unit.sv
// Two-stage RV32M multiply execute unit: magnitude front end, Multiplier32, sign fix-up back end.
module mul_issue_unit
   import mul_pkg::*;
#(
   parameter int unsigned TAG_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [MUL_OP_W-1:0]   in_op,
   input  logic [MUL_OPND_W-1:0] in_a,
   input  logic [MUL_OPND_W-1:0] in_b,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [MUL_RES_W-1:0]  out_data,
   output logic [TAG_W-1:0]      out_tag
);

   // Stage A registers
   logic                  a_valid;
   logic [MUL_OPND_W-1:0] a_mag_a;
   logic [MUL_OPND_W-1:0] a_mag_b;
   logic                  a_neg;
   logic [MUL_OP_W-1:0]   a_op;
   logic [TAG_W-1:0]      a_tag;

   // Stage B registers
   logic                  b_valid;
   logic [MUL_PROD_W-1:0] b_prod;
   logic                  b_neg;
   logic [MUL_OP_W-1:0]   b_op;
   logic [TAG_W-1:0]      b_tag;

   logic                  adv_a, adv_b, accept;
   logic                  sgn_a, sgn_b;
   logic [MUL_OPND_W-1:0] mag_a, mag_b;
   logic                  neg_in;
   logic [MUL_PROD_W-1:0] mult_prod;
   logic [MUL_PROD_W-1:0] fixed;

   assign adv_b    = !b_valid || out_ready;
   assign adv_a    = !a_valid || adv_b;
   assign in_ready = adv_a && !flush;
   assign accept   = in_valid && in_ready;

   // Operand signedness and magnitudes; MUL is treated as signed x signed since its low word is unaffected.
   always_comb begin
      sgn_a  = (in_op != MUL_OP_MULHU);
      sgn_b  = (in_op == MUL_OP_MUL) || (in_op == MUL_OP_MULH);
      mag_a  = (sgn_a && in_a[MUL_OPND_W-1]) ? (~in_a + 1'b1) : in_a;
      mag_b  = (sgn_b && in_b[MUL_OPND_W-1]) ? (~in_b + 1'b1) : in_b;
      neg_in = ((sgn_a && in_a[MUL_OPND_W-1]) ^ (sgn_b && in_b[MUL_OPND_W-1]))
               && (mag_a != '0) && (mag_b != '0);
   end

   // Stage A capture: holds while stage B is stalled, cleared by flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid <= 1'b0;
         a_mag_a <= '0;
         a_mag_b <= '0;
         a_neg   <= 1'b0;
         a_op    <= '0;
         a_tag   <= '0;
      end else if (flush) begin
         a_valid <= 1'b0;
      end else if (adv_a) begin
         a_valid <= accept;
         if (accept) begin
            a_mag_a <= mag_a;
            a_mag_b <= mag_b;
            a_neg   <= neg_in;
            a_op    <= in_op;
            a_tag   <= in_tag;
         end
      end
   end

   Multiplier32 u_mult (
      .a       (a_mag_a),
      .b       (a_mag_b),
      .product (mult_prod)
   );

   // Stage B capture: the product register is only rewritten when the consumer frees it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_valid <= 1'b0;
         b_prod  <= '0;
         b_neg   <= 1'b0;
         b_op    <= '0;
         b_tag   <= '0;
      end else if (flush) begin
         b_valid <= 1'b0;
      end else if (adv_b) begin
         b_valid <= a_valid;
         if (a_valid) begin
            b_prod <= mult_prod;
            b_neg  <= a_neg;
            b_op   <= a_op;
            b_tag  <= a_tag;
         end
      end
   end

   // Sign fix-up and word select
   always_comb begin
      fixed     = b_neg ? (~b_prod + 1'b1) : b_prod;
      out_data  = (b_op == MUL_OP_MUL) ? fixed[MUL_RES_W-1:0] : fixed[MUL_PROD_W-1:MUL_RES_W];
      out_tag   = b_tag;
      out_valid = b_valid;
   end

endmodule

// File: tb/tb_mul_issue_unit.sv
// Self-checking bench for mul_issue_unit against a signed-arithmetic reference model.
module tb_mul_issue_unit;
   import mul_pkg::*;

   localparam int unsigned TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [31:0]      in_a, in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;

   int checks   = 0;
   int failures = 0;
   int spurious = 0;

   typedef struct packed {
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
   } res_t;

   res_t exp_q[$];
   res_t got_q[$];
   res_t ref_q[$];

   always #5 clk = ~clk;

   mul_issue_unit #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   // Reference: full-width product of the operands as the ISA defines them, then pick a word
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint x, y, p;
      bit sa, sb;
      sa = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
      sb = (op == MUL_OP_MULH);
      x  = sa ? longint'($signed(a)) : longint'({32'b0, a});
      y  = sb ? longint'($signed(b)) : longint'({32'b0, b});
      p  = x * y;
      return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0000_0001;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Mid-cycle monitor: records accepted ops into the model queue and delivered results
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            got_q.push_back(res_t'{data: out_data, tag: out_tag});
            if (exp_q.size() > 0) ref_q.push_back(exp_q.pop_front());
            else spurious++;
         end
         if (flush) exp_q.delete();
         else if (in_valid && in_ready)
            exp_q.push_back(res_t'{data: model(in_op, in_a, in_b), tag: in_tag});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      flush    = 1'b0;
      in_valid = 1'b0;
      in_op    = '0;
      in_a     = '0;
      in_b     = '0;
      in_tag   = '0;
   endtask

   task automatic offer(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
   endtask

   task automatic clear_queues();
      got_q.delete();
      ref_q.delete();
      spurious = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      out_ready = 1'b1;
      drive_idle();
      repeat (3) tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
      checks++;
      if (out_tag !== '0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_directed();
      logic [1:0]       ops  [5] = '{MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU, MUL_OP_MULH};
      logic [31:0]      as   [5] = '{32'h3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
      logic [31:0]      bs   [5] = '{32'hFFFF_FFFB, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [31:0]      exps [5] = '{32'hFFFF_FFF1, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0};
      logic [TAG_W-1:0] tag;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tag = (i == 0) ? TAG_W'(7) : TAG_W'(i + 1);
         offer(ops[i], as[i], bs[i], tag);
         tick();
         drive_idle();
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_latency_early got=%b exp=0", i, out_valid); end
         tick();
         checks++;
         if (out_valid !== 1'b1) begin failures++; $display("FAIL dir%0d_out_valid got=%b exp=1", i, out_valid); end
         checks++;
         if (out_data !== exps[i]) begin failures++; $display("FAIL dir%0d_data got=%h exp=%h", i, out_data, exps[i]); end
         checks++;
         if (out_tag !== tag) begin failures++; $display("FAIL dir%0d_tag got=%h exp=%h", i, out_tag, tag); end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]       ops [4];
      logic [31:0]      as  [4];
      logic [31:0]      bs  [4];
      logic [31:0]      hold_data;
      logic [TAG_W-1:0] hold_tag;
      int               k, budget;
      clear_queues();
      for (int i = 0; i < 4; i++) begin
         ops[i] = 2'($urandom_range(0, 3));
         as[i]  = pick_operand();
         bs[i]  = pick_operand();
      end
      out_ready = 1'b0;
      offer(ops[0], as[0], bs[0], TAG_W'(10));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept0 got=%b exp=1", in_ready); end
      tick();
      offer(ops[1], as[1], bs[1], TAG_W'(11));
      #1;
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept1 got=%b exp=1", in_ready); end
      tick();
      offer(ops[2], as[2], bs[2], TAG_W'(12));
      hold_data = out_data;
      hold_tag  = out_tag;
      checks++;
      if (hold_data !== model(ops[0], as[0], bs[0])) begin
         failures++; $display("FAIL b2b_head_data got=%h exp=%h", hold_data, model(ops[0], as[0], bs[0]));
      end
      for (int s = 0; s < 3; s++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall%0d_in_ready got=%b exp=0", s, in_ready); end
         checks++;
         if (out_valid !== 1'b1 || out_data !== hold_data || out_tag !== hold_tag) begin
            failures++;
            $display("FAIL b2b_stall%0d_hold got=%b/%h/%h exp=1/%h/%h", s, out_valid, out_data, out_tag, hold_data, hold_tag);
         end
         tick();
      end
      out_ready = 1'b1;
      k = 2;
      budget = 20;
      while (got_q.size() < 4 && budget > 0) begin
         if (k < 4) offer(ops[k], as[k], bs[k], TAG_W'(10 + k));
         else in_valid = 1'b0;
         #1;
         if (in_valid && in_ready) k++;
         tick();
         budget--;
      end
      drive_idle();
      checks++;
      if (got_q.size() != 4 || ref_q.size() != 4) begin
         failures++; $display("FAIL b2b_count got=%0d exp=4", got_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q[i] !== ref_q[i] || got_q[i].tag !== TAG_W'(10 + i)) begin
               failures++;
               $display("FAIL b2b_result%0d got=%h/%h exp=%h/%h", i, got_q[i].data, got_q[i].tag, ref_q[i].data, TAG_W'(10 + i));
            end
         end
      end
   endtask

   task automatic test_flush();
      clear_queues();
      out_ready = 1'b1;
      // Flush with an empty pipeline still refuses the offered op
      offer(MUL_OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, TAG_W'(20));
      flush = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_empty_in_ready got=%b exp=0", in_ready); end
      tick();
      drive_idle();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty_not_taken got=%b exp=0", out_valid); end
      // Fill both stages, then flush with a new op offered
      out_ready = 1'b0;
      offer(MUL_OP_MUL, 32'd5, 32'd6, TAG_W'(1));
      tick();
      offer(MUL_OP_MULH, 32'hFFFF_FFFF, 32'd2, TAG_W'(2));
      tick();
      offer(MUL_OP_MUL, 32'd9, 32'd9, TAG_W'(21));
      flush = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_full_in_ready got=%b exp=0", in_ready); end
      tick();
      drive_idle();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_offer_dropped got=%b exp=0", out_valid); end
      out_ready = 1'b1;
      offer(MUL_OP_MULHSU, 32'h8000_0000, 32'h0000_0003, TAG_W'(22));
      tick();
      drive_idle();
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_post_early got=%b exp=0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFE || out_tag !== TAG_W'(22)) begin
         failures++;
         $display("FAIL flush_post_result got=%b/%h/%h exp=1/fffffffe/%h", out_valid, out_data, out_tag, TAG_W'(22));
      end
      tick();
      checks++;
      if (got_q.size() != 1 || spurious != 0) begin
         failures++; $display("FAIL flush_delivered got=%0d/%0d exp=1/0", got_q.size(), spurious);
      end
   endtask

   task automatic test_async_reset();
      clear_queues();
      out_ready = 1'b0;
      offer(MUL_OP_MULHU, 32'hDEAD_BEEF, 32'hCAFE_F00D, TAG_W'(3));
      tick();
      offer(MUL_OP_MUL, 32'h0001_0001, 32'h0002_0002, TAG_W'(4));
      tick();
      drive_idle();
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_preload got=%b exp=1", out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_data !== 32'h0) begin failures++; $display("FAIL arst_out_data got=%h exp=00000000", out_data); end
      checks++;
      if (out_tag !== '0) begin failures++; $display("FAIL arst_out_tag got=%h exp=0", out_tag); end
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_stale%0d got=%b exp=0", i, out_valid); end
      end
      checks++;
      if (spurious != 0 || got_q.size() != 0) begin
         failures++; $display("FAIL arst_no_results got=%0d exp=0", got_q.size());
      end
   endtask

   task automatic test_random();
      clear_queues();
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_op     = 2'($urandom_range(0, 3));
         in_a      = pick_operand();
         in_b      = pick_operand();
         in_tag    = TAG_W'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 49) == 0);
         tick();
      end
      drive_idle();
      out_ready = 1'b1;
      repeat (4) tick();
      checks++;
      if (exp_q.size() != 0 || spurious != 0) begin
         failures++; $display("FAIL rand_drain got=%0d/%0d exp=0/0", exp_q.size(), spurious);
      end
      checks++;
      if (got_q.size() != ref_q.size() || got_q.size() < 50) begin
         failures++; $display("FAIL rand_count got=%0d exp=%0d(>=50)", got_q.size(), ref_q.size());
      end
      for (int i = 0; i < got_q.size() && i < ref_q.size(); i++) begin
         checks++;
         if (got_q[i] !== ref_q[i]) begin
            failures++;
            $display("FAIL rand_result%0d got=%h/%h exp=%h/%h", i, got_q[i].data, got_q[i].tag, ref_q[i].data, ref_q[i].tag);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
